// File: rtl/sum_serial_nb.sv
// rtl/sum_serial_nb.sv - bit-serial adder/subtractor, one full-adder cell plus carry FF, LSB first
// start/busy/done handshake; S/Cout/ovf are registered and only change on completion or reset.

module sum_serial_nb #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] s_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             sbit_d;
  logic             c_d;
  logic [WIDTH-1:0] p_d;

  // The single full-adder cell; subtraction arrives as ~B with carry-in preset to 1.
  always_comb begin
    sbit_d = a_q[0] ^ b_q[0] ^ c_q;
    c_d    = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & c_q);
    p_d    = {sbit_d, p_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            c_q     <= sub_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          p_q   <= p_d;
          c_q   <= c_d;
          cnt_q <= cnt_q + 1'b1;
          // c_q here is the carry into the MSB, so ovf compares it with the carry out.
          if (cnt_q == LAST_BIT) begin
            s_q     <= p_d;
            cout_q  <= c_d;
            ovf_q   <= c_q ^ c_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign s_o    = s_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_sum_serial_nb.sv
// tb/tb_sum_serial_nb.sv - bench for sum_serial_nb at WIDTH=8 and WIDTH=16
// Arithmetic model of the handshake timing and results, plus literal directed checks.

module tb_sum_serial_nb;

  logic        clk;
  logic        rst_n;
  logic        start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, s8;
  logic        start16, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, s16;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model state per instance: one operation in flight at most, plus the last result.
  logic        pend_valid [2];
  int          pend_t     [2];
  int unsigned pend_s     [2];
  logic        pend_c     [2];
  logic        pend_v     [2];
  int unsigned held_s     [2];
  logic        held_c     [2];
  logic        held_v     [2];

  sum_serial_nb #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .sub_i(sub8), .a_i(a8), .b_i(b8),
    .busy_o(busy8), .done_o(done8), .s_o(s8), .cout_o(cout8), .ovf_o(ovf8)
  );

  sum_serial_nb #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .sub_i(sub16), .a_i(a16), .b_i(b16),
    .busy_o(busy16), .done_o(done16), .s_o(s16), .cout_o(cout16), .ovf_o(ovf16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, got no finish, want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int wid(input int d);
    return (d == 0) ? 8 : 16;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      pend_valid[d] = 1'b0;
      held_s[d] = 0;
      held_c[d] = 1'b0;
      held_v[d] = 1'b0;
    end
  endtask

  // Called in the time step of the accepting edge; cyc still holds the pre-edge count.
  task automatic push(input int d, input int unsigned a, input int unsigned b, input logic sb);
    int unsigned w, mask, full, s, sa, sbb, ss;
    w = wid(d);
    mask = (32'd1 << w) - 1;
    if (!sb) begin
      full = a + b;
      s = full & mask;
      pend_c[d] = ((full >> w) & 1) != 0;
    end else begin
      s = (a - b) & mask;
      pend_c[d] = (a >= b);
    end
    sa  = (a >> (w - 1)) & 1;
    sbb = (b >> (w - 1)) & 1;
    ss  = (s >> (w - 1)) & 1;
    pend_v[d] = sb ? ((sa != sbb) && (ss != sa)) : ((sa == sbb) && (ss != sa));
    pend_s[d] = s;
    pend_t[d] = cyc + 1;
    pend_valid[d] = 1'b1;
  endtask

  task automatic cmp_dut(input int d, input logic bz, input logic dn,
                         input int unsigned s, input logic c, input logic v);
    logic busy_exp, done_exp;
    int w;
    w = wid(d);
    busy_exp = pend_valid[d] && (cyc >= pend_t[d]) && (cyc < pend_t[d] + w);
    done_exp = pend_valid[d] && (cyc == pend_t[d] + w);
    if (done_exp) begin
      held_s[d] = pend_s[d];
      held_c[d] = pend_c[d];
      held_v[d] = pend_v[d];
      pend_valid[d] = 1'b0;
    end
    chk($sformatf("w%0d busy cyc%0d", w, cyc), bz, busy_exp);
    chk($sformatf("w%0d done cyc%0d", w, cyc), dn, done_exp);
    chk($sformatf("w%0d S cyc%0d", w, cyc), s, held_s[d]);
    chk($sformatf("w%0d Cout cyc%0d", w, cyc), c, held_c[d]);
    chk($sformatf("w%0d ovf cyc%0d", w, cyc), v, held_v[d]);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp_dut(0, busy8, done8, {24'd0, s8}, cout8, ovf8);
      cmp_dut(1, busy16, done16, {16'd0, s16}, cout16, ovf16);
    end
  end

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sb, input logic pulse,
                       input logic [7:0] es, input logic ec, input logic ev, input string nm);
    int k, nb;
    logic got;
    @(negedge clk);
    a8 = a; b8 = b; sub8 = sb; start8 = 1'b1;
    @(posedge clk);
    push(0, a, b, sb);
    #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = ~sb;
    k = 0; nb = 0; got = 1'b0;
    while (k < 40 && !got) begin
      @(negedge clk);
      if (done8) got = 1'b1;
      else begin
        if (busy8) nb++;
        k++;
        if (pulse && k == 3) begin
          start8 = 1'b1; a8 = ~a; b8 = ~b; sub8 = ~sb;
        end
        if (pulse && k == 4) start8 = 1'b0;
      end
    end
    chk({nm, " done seen"}, got, 1);
    chk({nm, " latency"}, k, 8);
    chk({nm, " busy cycles"}, nb, 8);
    chk({nm, " S"}, s8, es);
    chk({nm, " Cout"}, cout8, ec);
    chk({nm, " ovf"}, ovf8, ev);
  endtask

  task automatic set_in(input int d, input logic st, input int unsigned a, input int unsigned b,
                        input logic sb);
    if (d == 0) begin
      start8 = st; a8 = 8'(a); b8 = 8'(b); sub8 = sb;
    end else begin
      start16 = st; a16 = 16'(a); b16 = 16'(b); sub16 = sb;
    end
  endtask

  // Start held high: a new operation is accepted every WIDTH+1 edges.
  task automatic run_held(input int d, input int n);
    int unsigned w, mask, ra, rb;
    logic rs;
    w = wid(d);
    mask = (32'd1 << w) - 1;
    ra = $urandom & mask; rb = $urandom & mask; rs = 1'($urandom);
    @(negedge clk);
    set_in(d, 1'b1, ra, rb, rs);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      push(d, ra, rb, rs);
      for (int j = 0; j < int'(w); j++) begin
        @(negedge clk);
        set_in(d, 1'b1, $urandom & mask, $urandom & mask, 1'($urandom));
      end
      @(negedge clk);
      ra = $urandom & mask; rb = $urandom & mask; rs = 1'($urandom);
      set_in(d, (k < n - 1), ra, rb, rs);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy8", busy8, 0);
    chk("reset done8", done8, 0);
    chk("reset S8", s8, 0);
    chk("reset cout16", cout16, 0);
    chk("reset ovf16", ovf16, 0);
    rst_n = 1'b1;

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, "add 5A+3C");
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add FF+01");
    do_op(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "add 00+00");
    do_op(8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, "sub 10-20");
    do_op(8'h33, 8'h33, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "sub 33-33");
    do_op(8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0, "start during run");
    do_op(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, "sub 80-01");

    // Abort an operation while bit 4 is in progress.
    @(negedge clk);
    a8 = 8'h70; b8 = 8'h70; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    push(0, 8'h70, 8'h70, 1'b0);
    #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("async rst busy8", busy8, 0);
    chk("async rst done8", done8, 0);
    chk("async rst S8", s8, 0);
    chk("async rst cout8", cout8, 0);
    chk("async rst ovf8", ovf8, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    do_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, "after reset 01+02");

    run_held(0, 100);
    run_held(1, 100);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
